fwd_hazard_scoreboard: RTL
==========================

Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the two-stage forwarding unit, sitting between decode (ID) and the execute pipeline.
- Per cycle, for each of NUM_SRC source operands, it selects the youngest in-flight producer among FWD_STAGES pipeline stages.
- It detects load-use hazards.
- It tracks up to MC_SLOTS long-latency operations (mul/div) in a countdown scoreboard and raises a single stall that freezes ID until every hazard clears.

Parameters:
REG_AW, 5, register index width
NUM_SRC, 2, source operands checked per instruction
FWD_STAGES, 2, forwarding stages; stage 0 = youngest (EX/MEM), stage FWD_STAGES-1 = oldest (MEM/WB)
MC_SLOTS, 4, max concurrent long-latency ops
LAT_W, 4, width of latency field; max latency 2^LAT_W-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  instruction present in ID
id_rs  in  NUM_SRC*REG_AW  source indices; src s at [s*REG_AW +: REG_AW]
id_rs_used  in  NUM_SRC  per-source "operand actually read"
id_regwrite  in  1  ID instruction writes id_rd
id_rd  in  REG_AW  ID destination index
id_mc  in  1  ID instruction is long-latency
id_mc_lat  in  LAT_W  its latency in cycles
stg_regwrite  in  FWD_STAGES  per-stage write enable
stg_rd  in  FWD_STAGES*REG_AW  per-stage destination
stg_is_load  in  FWD_STAGES  per-stage load flag; only stage 0 is hazard-relevant
fwd_sel  out  NUM_SRC*SW  SW=$clog2(FWD_STAGES+1); 0 = regfile, k = stage k-1
stall  out  1  freeze PC/IF/ID, insert bubble
mc_full  out  1  all slots occupied
mc_done  out  1  a slot retired this cycle
mc_done_rd  out  REG_AW  rd of retiring slot (0 if none)

Behaviour:
- Reset (async, rst_n low): all slots invalid, counters 0, mc_done=0, mc_done_rd=0. Combinational outputs follow from the empty state: stall=0 when stage inputs are idle, mc_full=0.
- Forwarding (combinational):
  - For source s, fwd_sel = k+1 for the lowest k where stg_regwrite[k] && stg_rd[k]!=0 && stg_rd[k]==rs[s]. Otherwise 0.
  - Youngest stage wins.
  - x0 is never forwarded.
- Load-use:
  - Hazard when id_valid && id_rs_used[s] && stg_is_load[0] && stg_regwrite[0] && stg_rd[0]!=0 && stg_rd[0]==rs[s].
  - Loads in older stages forward normally.
- Scoreboard (sequential): each slot holds {valid, rd, cnt}.
  - MC RAW: id_rs_used[s] && rs[s]!=0 && a valid slot has rd==rs[s].
  - WAW: id_regwrite && id_rd!=0 && a valid slot has rd==id_rd. This applies to both normal and mc instructions.
  - Structural: id_mc && mc_full.
- stall = id_valid && (load-use || MC RAW || WAW || structural).
- Issue: on a rising edge with id_valid && id_mc && id_regwrite && id_rd!=0 && !stall, allocate the lowest-index free slot.
  - Set cnt = id_mc_lat, or 1 if id_mc_lat==0.
  - An mc op with rd==0 occupies no slot and never stalls on structural.
- Countdown: each valid slot decrements every cycle.
  - When cnt==1 at the edge, the slot is invalidated, and mc_done=1 with mc_done_rd=rd is registered for exactly one cycle.
  - Equal latencies cannot retire together, because the WAW check and per-cycle issue serialise them. If two slots would retire together, the lowest index reports and all retire regardless.
- Simultaneous events:
  - A slot with cnt==1 still counts as pending this cycle, so a dependent instruction stalls one more cycle.
  - Retire and issue in the same edge: the freed slot is reusable from the next cycle. mc_full is evaluated on current state only.
- Stall does not alter the scoreboard; counters continue.
- Reset mid-operation clears all slots immediately. No mc_done is emitted for discarded slots.

Test Plan:
- Stage0 regwrite rd=5 and stage1 regwrite rd=5, rs1=5, rs2=7 -> fwd_sel src0=1, src1=0, stall=0.
- Stage0 load rd=3, ID rs2=3 used -> stall=1 for one cycle. Next cycle the load is in stage1 -> fwd_sel src1=2, stall=0.
- Issue mc rd=9 lat=4 at cycle 0. ID reads rs1=9 at cycle 1 -> stall cycles 1-3. mc_done=1 with mc_done_rd=9 in cycle 4, stall=0 in cycle 4.
- Issue 4 mc ops (rd=1..4, lat=15) -> mc_full=1. A 5th mc issue (rd=6) -> stall=1 until the first retire, then it is allocated in slot 0.
- Non-mc ID instruction writes rd=9 while slot holds rd=9 -> stall (WAW). Any src=0 or mc rd=0 -> never stalls, fwd_sel=0.
- Assert rst_n=0 with 3 slots pending -> mc_full=0, mc_done stays 0. After release, reads of those rds do not stall.

Source files
------------

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard
// ID-stage hazard unit: per-source forwarding select from the youngest
// matching in-flight producer, load-use detection against the youngest
// stage, and a countdown scoreboard for long-latency (mul/div) results.
// A single stall output freezes PC/IF/ID while any hazard is present.
module fwd_hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int MC_SLOTS   = 4,
    parameter int LAT_W      = 4,
    localparam int SW        = $clog2(FWD_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]    id_rs,
    input  logic [NUM_SRC-1:0]           id_rs_used,
    input  logic                         id_regwrite,
    input  logic [REG_AW-1:0]            id_rd,
    input  logic                         id_mc,
    input  logic [LAT_W-1:0]             id_mc_lat,
    input  logic [FWD_STAGES-1:0]        stg_regwrite,
    input  logic [FWD_STAGES*REG_AW-1:0] stg_rd,
    input  logic [FWD_STAGES-1:0]        stg_is_load,
    output logic [NUM_SRC*SW-1:0]        fwd_sel,
    output logic                         stall,
    output logic                         mc_full,
    output logic                         mc_done,
    output logic [REG_AW-1:0]            mc_done_rd
);

    localparam int SLOT_W = (MC_SLOTS > 1) ? $clog2(MC_SLOTS) : 1;

    // Scoreboard slot state
    logic [MC_SLOTS-1:0] slot_vld_q, slot_vld_d;
    logic [REG_AW-1:0]   slot_rd_q  [MC_SLOTS];
    logic [REG_AW-1:0]   slot_rd_d  [MC_SLOTS];
    logic [LAT_W-1:0]    slot_cnt_q [MC_SLOTS];
    logic [LAT_W-1:0]    slot_cnt_d [MC_SLOTS];

    // Registered retire report
    logic                mc_done_q, mc_done_d;
    logic [REG_AW-1:0]   mc_done_rd_q, mc_done_rd_d;

    // Hazard terms
    logic                load_use;
    logic                mc_raw;
    logic                waw;
    logic                structural;
    logic                mc_wr;
    logic                issue;

    // Slot selection
    logic                free_found;
    logic [SLOT_W-1:0]   free_idx;
    logic                ret_found;
    logic [SLOT_W-1:0]   ret_idx;

    logic [REG_AW-1:0]   stg0_rd;

    // Only stage 0's load flag matters; older loads forward like any result.
    logic                unused_stg_load;

    assign stg0_rd         = stg_rd[REG_AW-1:0];
    assign unused_stg_load = ^stg_is_load;

    // Forwarding select: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (stg_regwrite[k] &&
                    (stg_rd[k*REG_AW +: REG_AW] != '0) &&
                    (stg_rd[k*REG_AW +: REG_AW] == id_rs[s*REG_AW +: REG_AW])) begin
                    fwd_sel[s*SW +: SW] = SW'(k + 1);
                end
            end
        end
    end

    // Hazard detection against stage 0 loads and pending scoreboard slots.
    always_comb begin
        load_use = 1'b0;
        mc_raw   = 1'b0;
        waw      = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_rs_used[s] && stg_is_load[0] && stg_regwrite[0] &&
                (stg0_rd != '0) && (stg0_rd == id_rs[s*REG_AW +: REG_AW])) begin
                load_use = 1'b1;
            end
        end
        for (int i = 0; i < MC_SLOTS; i++) begin
            if (slot_vld_q[i]) begin
                // A slot at its last count is still pending this cycle.
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (id_rs_used[s] && (id_rs[s*REG_AW +: REG_AW] != '0) &&
                        (slot_rd_q[i] == id_rs[s*REG_AW +: REG_AW])) begin
                        mc_raw = 1'b1;
                    end
                end
                if (id_regwrite && (id_rd != '0) && (slot_rd_q[i] == id_rd)) begin
                    waw = 1'b1;
                end
            end
        end
    end

    // mc ops targeting x0 never take a slot, so they never need one.
    assign mc_full    = &slot_vld_q;
    assign mc_wr      = id_mc && id_regwrite && (id_rd != '0);
    assign structural = mc_wr && mc_full;
    assign stall      = id_valid && (load_use || mc_raw || waw || structural);
    assign issue      = id_valid && mc_wr && !stall;

    // Lowest-index free slot for allocation and lowest-index retiring slot.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        ret_found  = 1'b0;
        ret_idx    = '0;
        for (int i = MC_SLOTS - 1; i >= 0; i--) begin
            if (!slot_vld_q[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
            if (slot_vld_q[i] && (slot_cnt_q[i] == LAT_W'(1))) begin
                ret_found = 1'b1;
                ret_idx   = SLOT_W'(i);
            end
        end
    end

    // Next slot state: count down, retire at one, allocate on issue.
    always_comb begin
        slot_vld_d   = slot_vld_q;
        slot_rd_d    = slot_rd_q;
        slot_cnt_d   = slot_cnt_q;
        mc_done_d    = ret_found;
        mc_done_rd_d = ret_found ? slot_rd_q[ret_idx] : '0;
        for (int i = 0; i < MC_SLOTS; i++) begin
            if (slot_vld_q[i]) begin
                if (slot_cnt_q[i] == LAT_W'(1)) begin
                    slot_vld_d[i] = 1'b0;
                end else begin
                    slot_cnt_d[i] = slot_cnt_q[i] - LAT_W'(1);
                end
            end
        end
        // A slot freed on this edge is not offered until the next cycle,
        // since free_idx only looks at currently invalid slots.
        if (issue && free_found) begin
            slot_vld_d[free_idx] = 1'b1;
            slot_rd_d[free_idx]  = id_rd;
            slot_cnt_d[free_idx] = (id_mc_lat == '0) ? LAT_W'(1) : id_mc_lat;
        end
    end

    // State registers; reset discards pending slots without reporting them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q   <= '0;
            mc_done_q    <= 1'b0;
            mc_done_rd_q <= '0;
            for (int i = 0; i < MC_SLOTS; i++) begin
                slot_rd_q[i]  <= '0;
                slot_cnt_q[i] <= '0;
            end
        end else begin
            slot_vld_q   <= slot_vld_d;
            mc_done_q    <= mc_done_d;
            mc_done_rd_q <= mc_done_rd_d;
            for (int i = 0; i < MC_SLOTS; i++) begin
                slot_rd_q[i]  <= slot_rd_d[i];
                slot_cnt_q[i] <= slot_cnt_d[i];
            end
        end
    end

    assign mc_done    = mc_done_q;
    assign mc_done_rd = mc_done_rd_q;

endmodule
